gmii_ptp_rx_parser: RTL
=======================

GMII_PTP_RX_PARSER -- requirements
Module: gmii_ptp_rx_parser

Interface
REQ-001 Parameter PTP_ETYPE, default 16'h88F7: Ethertype that identifies a layer-2 PTP frame.
REQ-002 Parameter MIN_LEN, default 64: minimum legal frame length in bytes, counted from the first byte after SFD and including FCS.
REQ-003 clk  input  1  single clock; GMII receive byte clock, one byte per cycle (giga mode only).
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 gmii_ctrl  input  1  GMII RX_DV; high while a frame is on the data bus.
REQ-006 gmii_data  input  8  GMII RXD byte.
REQ-007 sfd_pulse  output  1  one-cycle strobe marking SFD detection; timestamp capture point.
REQ-008 ptp_found  output  1  level; current or last frame is PTP.
REQ-009 ptp_msgid  output  4  PTP messageType of the last PTP frame.
REQ-010 frame_done  output  1  one-cycle strobe at frame end.
REQ-011 frame_len  output  16  byte count of the last frame; valid with frame_done.
REQ-012 frame_err  output  1  one-cycle strobe, coincident with frame_done, marking a bad frame.

Function
REQ-013 States SHALL be IDLE, PREAMBLE, BODY and DROP; all outputs SHALL be registered.
REQ-014 IDLE: ctrl=1 and data=8'h55 -> PREAMBLE; ctrl=1 and any other data -> DROP; ctrl=0 -> stay.
REQ-015 PREAMBLE: data=8'h55 -> stay; data=8'hD5 -> BODY with byte counter cleared to 0; other data -> DROP; ctrl=0 -> IDLE with frame_done=1, frame_err=1 and frame_len=0 the next cycle.
REQ-016 sfd_pulse SHALL be high for exactly the one cycle after the cycle that sampled 8'hD5 in PREAMBLE.
REQ-017 BODY: each ctrl=1 cycle increments the byte counter; the counter saturates at 16'hFFFF.
REQ-018 Ethertype is bytes 12-13 (big-endian) of BODY; if it equals 16'h8100, the Ethertype is bytes 16-17 instead (one VLAN tag only).
REQ-019 When the Ethertype matches PTP_ETYPE, the next byte (PTP byte 0) SHALL be captured: ptp_msgid <= data[3:0] and ptp_found <= 1, both visible one cycle after that byte is sampled.
REQ-020 ptp_found and ptp_msgid SHALL hold until the next sfd_pulse; sfd_pulse clears ptp_found to 0 in the same cycle.
REQ-021 BODY with ctrl=0 -> IDLE. The next cycle SHALL assert frame_done=1 with frame_len equal to the counter; frame_err=1 if frame_len < MIN_LEN.
REQ-022 A frame that ends before PTP byte 0 has been sampled SHALL leave ptp_found=0.
REQ-023 DROP: stay while ctrl=1; ctrl=0 -> IDLE, with frame_done=1, frame_err=1 and frame_len=0 the next cycle.
REQ-024 A single ctrl=0 cycle SHALL always terminate the frame; ctrl=1 on the very next cycle starts a new frame, evaluated in IDLE rules in that same cycle.

Reset
REQ-025 While rst=1 (sampled on clk), the state SHALL go to IDLE, the counter to 0, and sfd_pulse, ptp_found, ptp_msgid, frame_done, frame_len and frame_err SHALL all go to 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no frame_done. If ctrl is still 1 after release, the remaining bytes are handled as a new frame under IDLE rules, so a non-0x55 byte leads to DROP.

Verification
REQ-027 Scenario: 7x55, D5, 12 address bytes, 88F7, byte 8'h00, padding to 64 bytes -> sfd_pulse one cycle after D5; ptp_found=1 with ptp_msgid=0 one cycle after PTP byte 0; frame_done with frame_len=64 and frame_err=0.
REQ-028 Scenario: VLAN-tagged frame (8100, tag, 88F7, byte 8'h09), 68 bytes -> ptp_msgid=9, ptp_found=1, frame_len=68, frame_err=0.
REQ-029 Scenario: IPv4 frame (0800), 100 bytes, following a PTP frame -> ptp_found drops to 0 at this frame's sfd_pulse and stays 0; frame_len=100.
REQ-030 Scenario: runt frame of 40 bytes with ctrl low for one cycle, immediately followed by a 64-byte frame -> first frame_done with frame_err=1 and frame_len=40; second frame parsed normally with sfd_pulse present.
REQ-031 Scenario: frame starting with 8'hAB, and a preamble corrupted with 8'h54 -> frame_done with frame_err=1 and frame_len=0; no sfd_pulse.
REQ-032 Scenario: rst pulsed at byte 30 of a PTP frame -> all outputs 0; no frame_done for the aborted frame; the remainder of the frame results in DROP with frame_err=1.

Source files
------------

// File: rtl/gmii_ptp_rx_parser_if.sv
// GMII receive bus plus the parser's timestamp/frame status outputs.
// The slave modport is the parser's view; the master modport is the PHY/consumer view.
interface gmii_ptp_rx_parser_if;
  logic        gmii_ctrl;
  logic [7:0]  gmii_data;
  logic        sfd_pulse;
  logic        ptp_found;
  logic [3:0]  ptp_msgid;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;

  modport master (
    output gmii_ctrl, gmii_data,
    input  sfd_pulse, ptp_found, ptp_msgid, frame_done, frame_len, frame_err
  );

  modport slave (
    input  gmii_ctrl, gmii_data,
    output sfd_pulse, ptp_found, ptp_msgid, frame_done, frame_len, frame_err
  );
endinterface

// File: rtl/gmii_ptp_rx_parser.sv
// GMII receive-side frame parser: detects SFD for timestamping, measures frame
// length and flags layer-2 PTP frames (optionally behind one VLAN tag).
//
// state    | meaning
// IDLE     | bus idle, waiting for the first preamble byte
// PREAMBLE | receiving 0x55 bytes, waiting for SFD 0xD5
// BODY     | counting bytes after SFD, parsing the Ethertype
// DROP     | malformed start, discard until ctrl falls
module gmii_ptp_rx_parser #(
  parameter logic [15:0] PTP_ETYPE = 16'h88F7,
  parameter int          MIN_LEN   = 64
) (
  input logic clk,
  input logic rst,
  gmii_ptp_rx_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;

  localparam logic [15:0] MIN_LEN_W  = 16'(MIN_LEN);
  localparam logic [15:0] VLAN_ETYPE = 16'h8100;

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  et_hi;
  logic        vlan;
  logic        ptp_pend;

  logic        sfd_pulse;
  logic        ptp_found;
  logic [3:0]  ptp_msgid;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;

  logic        ctrl;
  logic [7:0]  data;
  logic [15:0] hi_idx;
  logic [15:0] lo_idx;

  assign ctrl   = bus.gmii_ctrl;
  assign data   = bus.gmii_data;
  assign hi_idx = vlan ? 16'd16 : 16'd12;
  assign lo_idx = vlan ? 16'd17 : 16'd13;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      et_hi      <= '0;
      vlan       <= 1'b0;
      ptp_pend   <= 1'b0;
      sfd_pulse  <= 1'b0;
      ptp_found  <= 1'b0;
      ptp_msgid  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sfd_pulse  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl) state <= (data == 8'h55) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!ctrl) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            frame_len  <= '0;
          end else if (data == 8'hD5) begin
            state     <= BODY;
            cnt       <= '0;
            vlan      <= 1'b0;
            ptp_pend  <= 1'b0;
            sfd_pulse <= 1'b1;
            ptp_found <= 1'b0;
          end else if (data != 8'h55) begin
            state <= DROP;
          end
        end
        BODY: begin
          if (!ctrl) begin
            state      <= IDLE;
            ptp_pend   <= 1'b0;
            frame_done <= 1'b1;
            frame_len  <= cnt;
            frame_err  <= (cnt < MIN_LEN_W);
          end else begin
            if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (ptp_pend) begin
              ptp_msgid <= data[3:0];
              ptp_found <= 1'b1;
              ptp_pend  <= 1'b0;
            end
            if (cnt == hi_idx) et_hi <= data;
            // Only the outer Ethertype may select the VLAN path; one tag at most.
            if (cnt == lo_idx) begin
              if (!vlan && {et_hi, data} == VLAN_ETYPE) vlan <= 1'b1;
              else if ({et_hi, data} == PTP_ETYPE) ptp_pend <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!ctrl) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            frame_len  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sfd_pulse  = sfd_pulse;
  assign bus.ptp_found  = ptp_found;
  assign bus.ptp_msgid  = ptp_msgid;
  assign bus.frame_done = frame_done;
  assign bus.frame_len  = frame_len;
  assign bus.frame_err  = frame_err;

endmodule
